// File: rtl/cdb_pkg.sv
// Shared definitions for the CDB transmit path: default widths, functional-unit
// source encodings, the broadcast packet type and the round-robin successor.
package cdb_pkg;

   localparam int CDB_TAG_W  = 5;
   localparam int CDB_DATA_W = 32;

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_MUL = 2'd1;
   localparam logic [1:0] SRC_LSU = 2'd2;

   typedef struct packed {
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
      logic [1:0]            src;
   } cdb_pkt_t;

   // Next unit in the ALU -> MUL -> LSU -> ALU search ring.
   function automatic logic [1:0] src_next(input logic [1:0] s);
      logic [1:0] n;
      case (s)
         SRC_ALU: n = SRC_MUL;
         SRC_MUL: n = SRC_LSU;
         default: n = SRC_ALU;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-unit result FIFO: circular buffer with naturally wrapping pointers and an
// occupancy count. full/empty come from registered state only. Flush wins over
// push and pop.
module cdb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W:0]   count_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == (PTR_W+1)'(DEPTH));
   assign empty     = (count_r == '0);
   assign head      = mem_r[rd_ptr_r];
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head never shows stale X data.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: buffers ALU/MUL/LSU results in per-unit FIFOs, grants
// one head per cycle and drives the registered broadcast.
// Build option: define CDB_FIXED_PRIO_EN for fixed priority LSU > MUL > ALU
// instead of the default round-robin search.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int TAG_W      = CDB_TAG_W,
   parameter int DATA_W     = CDB_DATA_W
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              flush_i,
   input  logic              alu_valid_i,
   input  logic [TAG_W-1:0]  alu_tag_i,
   input  logic [DATA_W-1:0] alu_data_i,
   output logic              alu_ready_o,
   input  logic              mul_valid_i,
   input  logic [TAG_W-1:0]  mul_tag_i,
   input  logic [DATA_W-1:0] mul_data_i,
   output logic              mul_ready_o,
   input  logic              lsu_valid_i,
   input  logic [TAG_W-1:0]  lsu_tag_i,
   input  logic [DATA_W-1:0] lsu_data_i,
   output logic              lsu_ready_o,
   output logic              cdb_en_o,
   output logic [TAG_W-1:0]  cdb_tag_o,
   output logic [DATA_W-1:0] cdb_data_o,
   output logic [1:0]        cdb_src_o,
   output logic              busy_o
);

   localparam int ENT_W = TAG_W + DATA_W;

   logic [2:0]        valid_s;
   logic [2:0]        push_s;
   logic [2:0]        pop_s;
   logic [2:0]        full_s;
   logic [2:0]        empty_s;
   logic [2:0]        req_s;
   logic [ENT_W-1:0]  wr_s   [3];
   logic [ENT_W-1:0]  head_s [3];
   logic [ENT_W-1:0]  win_head_s;
   logic              grant_s;
   logic [1:0]        win_s;
   logic              cdb_en_r;
   logic [TAG_W-1:0]  cdb_tag_r;
   logic [DATA_W-1:0] cdb_data_r;
   logic [1:0]        cdb_src_r;

   assign valid_s = {lsu_valid_i, mul_valid_i, alu_valid_i};
   assign wr_s[0] = {alu_tag_i, alu_data_i};
   assign wr_s[1] = {mul_tag_i, mul_data_i};
   assign wr_s[2] = {lsu_tag_i, lsu_data_i};

   // Ready depends only on registered occupancy, never on this cycle's pop.
   assign alu_ready_o = !full_s[0];
   assign mul_ready_o = !full_s[1];
   assign lsu_ready_o = !full_s[2];

   // Anything offered during a flush cycle is dropped.
   assign push_s = valid_s & ~full_s & {3{!flush_i}};
   assign req_s  = ~empty_s;

   for (genvar g = 0; g < 3; g++) begin : g_fifo
      cdb_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (ENT_W)
      ) u_fifo (
         .clk_i    (clk_i),
         .reset_ni (reset_ni),
         .push     (push_s[g]),
         .pop      (pop_s[g]),
         .flush    (flush_i),
         .wr_data  (wr_s[g]),
         .full     (full_s[g]),
         .empty    (empty_s[g]),
         .head     (head_s[g])
      );
   end

`ifdef CDB_FIXED_PRIO_EN
   // Fixed-priority winner selection: LSU first, then MUL, then ALU.
   always_comb begin
      grant_s = 1'b0;
      win_s   = SRC_ALU;
      if (req_s[2]) begin
         grant_s = 1'b1;
         win_s   = SRC_LSU;
      end else if (req_s[1]) begin
         grant_s = 1'b1;
         win_s   = SRC_MUL;
      end else if (req_s[0]) begin
         grant_s = 1'b1;
         win_s   = SRC_ALU;
      end else begin
         grant_s = 1'b0;
      end
   end
`else
   logic [1:0] rr_ptr_r;
   logic [1:0] cand_s;

   // Round-robin search starting at the pointer; first requester wins.
   always_comb begin
      grant_s = 1'b0;
      win_s   = SRC_ALU;
      cand_s  = rr_ptr_r;
      for (int i = 0; i < 3; i++) begin
         if (grant_s) begin
            cand_s = cand_s;
         end else if (req_s[cand_s]) begin
            grant_s = 1'b1;
            win_s   = cand_s;
         end else begin
            cand_s = src_next(cand_s);
         end
      end
   end

   // Pointer moves past the winner only on a real grant; flush restores ALU.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rr_ptr_r <= SRC_ALU;
      end else if (flush_i) begin
         rr_ptr_r <= SRC_ALU;
      end else if (grant_s) begin
         rr_ptr_r <= src_next(win_s);
      end
   end
`endif

   // Pop strobe and head mux for the granted unit.
   always_comb begin
      pop_s      = 3'b000;
      win_head_s = head_s[0];
      case (win_s)
         SRC_ALU: win_head_s = head_s[0];
         SRC_MUL: win_head_s = head_s[1];
         SRC_LSU: win_head_s = head_s[2];
         default: win_head_s = head_s[0];
      endcase
      if (grant_s && !flush_i) begin
         case (win_s)
            SRC_ALU: pop_s = 3'b001;
            SRC_MUL: pop_s = 3'b010;
            SRC_LSU: pop_s = 3'b100;
            default: pop_s = 3'b000;
         endcase
      end else begin
         pop_s = 3'b000;
      end
   end

   // Broadcast register: one-cycle pulse per grant, payload held when idle.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cdb_en_r   <= 1'b0;
         cdb_tag_r  <= '0;
         cdb_data_r <= '0;
         cdb_src_r  <= SRC_ALU;
      end else if (flush_i) begin
         cdb_en_r <= 1'b0;
      end else if (grant_s) begin
         cdb_en_r   <= 1'b1;
         cdb_tag_r  <= win_head_s[ENT_W-1:DATA_W];
         cdb_data_r <= win_head_s[DATA_W-1:0];
         cdb_src_r  <= win_s;
      end else begin
         cdb_en_r <= 1'b0;
      end
   end

   assign cdb_en_o   = cdb_en_r;
   assign cdb_tag_o  = cdb_tag_r;
   assign cdb_data_o = cdb_data_r;
   assign cdb_src_o  = cdb_src_r;
   assign busy_o     = (|req_s) | cdb_en_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: cycle vector table for single/round-robin/flush basics,
// per-unit scoreboard queues checked on every broadcast, and hand sequences for
// backpressure, flush, asynchronous reset and random fairness traffic.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        flush_i;
   logic        alu_valid_i, mul_valid_i, lsu_valid_i;
   logic [4:0]  alu_tag_i, mul_tag_i, lsu_tag_i;
   logic [31:0] alu_data_i, mul_data_i, lsu_data_i;
   logic        alu_ready_o, mul_ready_o, lsu_ready_o;
   logic        cdb_en_o;
   logic [4:0]  cdb_tag_o;
   logic [31:0] cdb_data_o;
   logic [1:0]  cdb_src_o;
   logic        busy_o;

   cdb_arbiter dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(flush_i),
      .alu_valid_i(alu_valid_i), .alu_tag_i(alu_tag_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
      .mul_valid_i(mul_valid_i), .mul_tag_i(mul_tag_i), .mul_data_i(mul_data_i), .mul_ready_o(mul_ready_o),
      .lsu_valid_i(lsu_valid_i), .lsu_tag_i(lsu_tag_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
      .cdb_en_o(cdb_en_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o), .cdb_src_o(cdb_src_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        fl, av, mv, lv;
      logic [4:0]  at, mt, lt;
      logic [31:0] ad, md, ld;
      logic        e_en;
      logic [1:0]  e_src;
      logic [4:0]  e_tag;
      logic [31:0] e_data;
      logic        e_busy;
      logic [2:0]  e_rdy;
   } vec_t;

   vec_t        tv [9];
   cdb_pkt_t    q_alu[$], q_mul[$], q_lsu[$];
   logic [4:0]  mul_seen[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        rr_chk_en  = 1'b0;
   logic        mul_log_en = 1'b0;
   logic        last_vld   = 1'b0;
   logic [1:0]  last_src   = 2'd0;
   logic [2:0]  ne_snap    = 3'b000;

   function automatic vec_t mk(input logic fl, av, mv, lv, input logic [4:0] at, mt, lt,
                               input logic [31:0] ad, md, ld, input logic e_en,
                               input logic [1:0] e_src, input logic [4:0] e_tag,
                               input logic [31:0] e_data, input logic e_busy, input logic [2:0] e_rdy);
      vec_t v;
      v.fl = fl; v.av = av; v.mv = mv; v.lv = lv; v.at = at; v.mt = mt; v.lt = lt;
      v.ad = ad; v.md = md; v.ld = ld; v.e_en = e_en; v.e_src = e_src; v.e_tag = e_tag;
      v.e_data = e_data; v.e_busy = e_busy; v.e_rdy = e_rdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event, expected none", name);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      flush_i = 1'b0;
      alu_valid_i = 1'b0; mul_valid_i = 1'b0; lsu_valid_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while (busy_o && c < 50) begin
         step();
         c++;
      end
      if (busy_o) note_fail(name);
      @(negedge clk_i);
      #1;
   endtask

   // Scoreboard: record accepted results at posedge, check broadcasts at negedge.
   task automatic monitor();
      cdb_pkt_t e;
      logic     got;
      forever begin
         @(posedge clk_i or negedge clk_i or negedge reset_ni);
         if (!reset_ni) begin
            q_alu.delete(); q_mul.delete(); q_lsu.delete();
            last_vld = 1'b0;
         end else if (clk_i) begin
            if (flush_i) begin
               q_alu.delete(); q_mul.delete(); q_lsu.delete();
               last_vld = 1'b0;
            end else begin
               if (alu_valid_i && alu_ready_o) q_alu.push_back('{tag: alu_tag_i, data: alu_data_i, src: SRC_ALU});
               if (mul_valid_i && mul_ready_o) q_mul.push_back('{tag: mul_tag_i, data: mul_data_i, src: SRC_MUL});
               if (lsu_valid_i && lsu_ready_o) q_lsu.push_back('{tag: lsu_tag_i, data: lsu_data_i, src: SRC_LSU});
            end
         end else begin
            if (cdb_en_o) begin
               if (rr_chk_en && last_vld)
                  chk("rr_fair", 32'((cdb_src_o == last_src) && ((ne_snap & ~(3'b001 << cdb_src_o)) != 3'b000)), 32'd0);
               last_src = cdb_src_o;
               last_vld = 1'b1;
               if (mul_log_en && cdb_src_o == SRC_MUL) mul_seen.push_back(cdb_tag_o);
               got = 1'b0;
               case (cdb_src_o)
                  SRC_ALU: if (q_alu.size() == 0) note_fail("cdb_extra_alu"); else begin e = q_alu.pop_front(); got = 1'b1; end
                  SRC_MUL: if (q_mul.size() == 0) note_fail("cdb_extra_mul"); else begin e = q_mul.pop_front(); got = 1'b1; end
                  SRC_LSU: if (q_lsu.size() == 0) note_fail("cdb_extra_lsu"); else begin e = q_lsu.pop_front(); got = 1'b1; end
                  default: note_fail("cdb_src_range");
               endcase
               if (got) begin
                  chk("sb_tag", 32'(cdb_tag_o), 32'(e.tag));
                  chk("sb_data", cdb_data_o, e.data);
               end
            end
            ne_snap = {q_lsu.size() != 0, q_mul.size() != 0, q_alu.size() != 0};
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int        idx, cyc;
      logic      acc, saw_low;
      logic [1:0] exp_ord [3];

      reset_ni = 1'b0;
      alu_tag_i = 5'd0; mul_tag_i = 5'd0; lsu_tag_i = 5'd0;
      alu_data_i = 32'd0; mul_data_i = 32'd0; lsu_data_i = 32'd0;
      idle_inputs();
      fork monitor(); join_none

      // Vector table: inputs applied for one edge, outputs expected after it.
      tv[0] = mk(0,1,0,0, 5'd7,5'd0,5'd0, 32'hDEADBEEF,32'd0,32'd0, 0,2'd0,5'd0,32'd0, 1,3'b111);
      tv[1] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0,        1,2'd0,5'd7,32'hDEADBEEF, 1,3'b111);
      tv[2] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0,        0,2'd0,5'd7,32'hDEADBEEF, 0,3'b111);
      tv[3] = mk(1,1,0,0, 5'd3,5'd0,5'd0, 32'h33,32'd0,32'd0,       0,2'd0,5'd7,32'hDEADBEEF, 0,3'b111);
      tv[4] = mk(0,1,1,1, 5'd10,5'd11,5'd12, 32'hA0A0000A,32'hB0B0000B,32'hC0C0000C, 0,2'd0,5'd7,32'hDEADBEEF, 1,3'b111);
`ifdef CDB_FIXED_PRIO_EN
      tv[5] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0, 1,2'd2,5'd12,32'hC0C0000C, 1,3'b111);
      tv[6] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0, 1,2'd1,5'd11,32'hB0B0000B, 1,3'b111);
      tv[7] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0, 1,2'd0,5'd10,32'hA0A0000A, 1,3'b111);
      tv[8] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0, 0,2'd0,5'd10,32'hA0A0000A, 0,3'b111);
      exp_ord[0] = 2'd2; exp_ord[1] = 2'd1; exp_ord[2] = 2'd0;
`else
      tv[5] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0, 1,2'd0,5'd10,32'hA0A0000A, 1,3'b111);
      tv[6] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0, 1,2'd1,5'd11,32'hB0B0000B, 1,3'b111);
      tv[7] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0, 1,2'd2,5'd12,32'hC0C0000C, 1,3'b111);
      tv[8] = mk(0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0, 0,2'd2,5'd12,32'hC0C0000C, 0,3'b111);
      exp_ord[0] = 2'd0; exp_ord[1] = 2'd1; exp_ord[2] = 2'd2;
`endif

      // Reset values while reset is held.
      #12;
      chk("rst_en", 32'(cdb_en_o), 32'd0);
      chk("rst_tag", 32'(cdb_tag_o), 32'd0);
      chk("rst_data", cdb_data_o, 32'd0);
      chk("rst_src", 32'(cdb_src_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_ready", 32'({lsu_ready_o, mul_ready_o, alu_ready_o}), 32'd7);
      reset_ni = 1'b1;

      for (int i = 0; i < 9; i++) begin
         flush_i = tv[i].fl;
         alu_valid_i = tv[i].av; mul_valid_i = tv[i].mv; lsu_valid_i = tv[i].lv;
         alu_tag_i = tv[i].at; mul_tag_i = tv[i].mt; lsu_tag_i = tv[i].lt;
         alu_data_i = tv[i].ad; mul_data_i = tv[i].md; lsu_data_i = tv[i].ld;
         step();
         chk($sformatf("v%0d_en", i), 32'(cdb_en_o), 32'(tv[i].e_en));
         chk($sformatf("v%0d_src", i), 32'(cdb_src_o), 32'(tv[i].e_src));
         chk($sformatf("v%0d_tag", i), 32'(cdb_tag_o), 32'(tv[i].e_tag));
         chk($sformatf("v%0d_data", i), cdb_data_o, tv[i].e_data);
         chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(tv[i].e_busy));
         chk($sformatf("v%0d_rdy", i), 32'({lsu_ready_o, mul_ready_o, alu_ready_o}), 32'(tv[i].e_rdy));
      end
      idle_inputs();

      // Backpressure: four MUL results while the ALU floods.
      mul_seen.delete();
      mul_log_en = 1'b1;
      saw_low = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 40) begin
         mul_valid_i = 1'b1; mul_tag_i = 5'(idx + 1); mul_data_i = 32'h4D00_0000 + 32'(idx);
         alu_valid_i = 1'b1; alu_tag_i = 5'(16 + cyc % 16); alu_data_i = 32'hA100_0000 + 32'(cyc);
         acc = mul_ready_o;
         if (!mul_ready_o) saw_low = 1'b1;
         step();
         if (acc) idx++;
         cyc++;
      end
      if (idx < 4) note_fail("bp_accept_timeout");
      idle_inputs();
      drain("bp_drain_timeout");
      mul_log_en = 1'b0;
`ifndef CDB_FIXED_PRIO_EN
      chk("bp_mul_ready_low", 32'(saw_low), 32'd1);
`endif
      chk("bp_mul_count", 32'(mul_seen.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < mul_seen.size()) chk($sformatf("bp_mul_order%0d", i), 32'(mul_seen[i]), 32'(i + 1));
      end
      chk("bp_lost", 32'(q_alu.size() + q_mul.size() + q_lsu.size()), 32'd0);

      // Flush with results buffered in every FIFO; flush-cycle inputs discarded.
      for (int i = 0; i < 3; i++) begin
         flush_i = (i == 2);
         alu_valid_i = 1'b1; mul_valid_i = 1'b1; lsu_valid_i = 1'b1;
         alu_tag_i = 5'(1 + 3 * i); mul_tag_i = 5'(2 + 3 * i); lsu_tag_i = 5'(3 + 3 * i);
         alu_data_i = 32'h1000 + 32'(i); mul_data_i = 32'h2000 + 32'(i); lsu_data_i = 32'h3000 + 32'(i);
         step();
      end
      idle_inputs();
      chk("fl_en", 32'(cdb_en_o), 32'd0);
      chk("fl_ready", 32'({lsu_ready_o, mul_ready_o, alu_ready_o}), 32'd7);
      chk("fl_busy", 32'(busy_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("fl_quiet%0d", i), 32'(cdb_en_o), 32'd0);
      end
      alu_valid_i = 1'b1; alu_tag_i = 5'd9; alu_data_i = 32'h0000_0099;
      step();
      idle_inputs();
      step();
      chk("fl_after_en", 32'(cdb_en_o), 32'd1);
      chk("fl_after_tag", 32'(cdb_tag_o), 32'd9);
      chk("fl_after_src", 32'(cdb_src_o), 32'(SRC_ALU));
      drain("fl_drain_timeout");

      // Asynchronous reset while a broadcast is on the bus.
      alu_valid_i = 1'b1; alu_tag_i = 5'd5; alu_data_i = 32'h55;
      step();
      idle_inputs();
      cyc = 0;
      while (!cdb_en_o && cyc < 10) begin
         step();
         cyc++;
      end
      if (!cdb_en_o) note_fail("ar_wait_en_timeout");
      #2;
      reset_ni = 1'b0;
      #1;
      chk("ar_en_immediate", 32'(cdb_en_o), 32'd0);
      chk("ar_busy", 32'(busy_o), 32'd0);
      chk("ar_ready", 32'({lsu_ready_o, mul_ready_o, alu_ready_o}), 32'd7);
      @(negedge clk_i);
      #1;
      reset_ni = 1'b1;
      alu_valid_i = 1'b1; mul_valid_i = 1'b1; lsu_valid_i = 1'b1;
      alu_tag_i = 5'd20; mul_tag_i = 5'd21; lsu_tag_i = 5'd22;
      step();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("ar_order%0d", i), 32'(cdb_src_o), 32'(exp_ord[i]));
      end
      drain("ar_drain_timeout");

      // Random traffic from all three units with fairness tracking.
`ifndef CDB_FIXED_PRIO_EN
      rr_chk_en = 1'b1;
`endif
      for (int i = 0; i < 30; i++) begin
         alu_valid_i = 1'($urandom_range(0, 1)); alu_tag_i = 5'($urandom); alu_data_i = $urandom;
         mul_valid_i = 1'($urandom_range(0, 1)); mul_tag_i = 5'($urandom); mul_data_i = $urandom;
         lsu_valid_i = 1'($urandom_range(0, 1)); lsu_tag_i = 5'($urandom); lsu_data_i = $urandom;
         step();
      end
      idle_inputs();
      drain("rnd_drain_timeout");
      rr_chk_en = 1'b0;
      chk("rnd_lost", 32'(q_alu.size() + q_mul.size() + q_lsu.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
